// File: rtl/cla_adder_pipe_if.sv
// -----------------------------------------------------------------------------
// cla_adder_pipe_if
//   Handshake bundle for the pipelined CLA add/subtract unit.
//   Input channel : in_valid/in_ready, a, b, op, cin
//   Output channel: out_valid/out_ready, sum, cout, ovf, zero
//   master : the side that issues operations and consumes results
//   slave  : the adder itself
// -----------------------------------------------------------------------------
interface cla_adder_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// cla_adder_pipe
//   Three-stage pipelined carry-lookahead add/subtract unit.
//   S1 registers operands (b already conditionally inverted, carry-in resolved),
//   S2 registers bit propagate/generate plus the per-group carry-in vector from
//   a two-level lookahead, S3 registers sum and flags.
//   Valid/ready on both sides; bubbles collapse, backpressure stalls.
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      cla_adder_pipe_if.slave (operands in, result + cout/ovf/zero out)
//
// Parameters
//   WIDTH    operand width, multiple of GROUP, at least 4
//   GROUP    bits per first-level lookahead group
//   SATURATE 1 = clamp signed overflow to the most positive / negative value
// -----------------------------------------------------------------------------
module cla_adder_pipe #(
  parameter int WIDTH    = 16,
  parameter int GROUP    = 4,
  parameter bit SATURATE = 1'b0
) (
  input logic             clk,
  input logic             reset_n,
  cla_adder_pipe_if.slave bus
);

  localparam int NG = WIDTH / GROUP;

  // Carry into position j of a lookahead block, as a flat sum of products:
  //   c_j = OR_{m<j} ( g_m & AND_{m<t<j} p_t )  |  ( AND_{t<j} p_t & c )
  // No term depends on another carry, so nothing ripples. Callers zero-extend
  // narrower p/g vectors; only positions below j contribute.
  function automatic logic sop_carry(input logic [WIDTH-1:0] p,
                                     input logic [WIDTH-1:0] g,
                                     input logic             c,
                                     input int               j);
    logic carry;
    logic all_p;
    logic term;
    carry = 1'b0;
    all_p = c;
    for (int m = 0; m < WIDTH; m++) begin
      if (m < j) begin
        term = g[m];
        for (int t = 0; t < WIDTH; t++) begin
          if (t > m && t < j) term = term & p[t];
        end
        carry = carry | term;
        all_p = all_p & p[m];
      end
    end
    return carry | all_p;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake: combinational ready chain from the output back to the input.
  // ---------------------------------------------------------------------------
  logic v1, v2, v3;
  logic acc2, acc3, in_ready;

  assign acc3     = !v3 || bus.out_ready;
  assign acc2     = !v2 || acc3;
  assign in_ready = !v1 || acc2;

  // ---------------------------------------------------------------------------
  // Effective operands
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // NOTE: every variable written in an always_comb gets a value on every path
  // (here via the default arm) so no latch is inferred.
  always_comb begin
    b_eff = bus.op[0] ? ~bus.b : bus.b;
    case (bus.op)
      2'b00:   c0 = 1'b0;
      2'b01:   c0 = 1'b1;
      2'b10:   c0 = bus.cin;
      default: c0 = ~bus.cin;
    endcase
  end

  // ---------------------------------------------------------------------------
  // S1: input register
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a1, b1;
  logic             c1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      c1 <= 1'b0;
    end else if (in_ready) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        a1 <= bus.a;
        b1 <= b_eff;
        c1 <= c0;
      end
    end
  end

  // Bit P/G and second-level group lookahead. grp_c[k] is the carry into
  // group k; grp_c[NG] is the carry out of the MSB.
  logic [WIDTH-1:0] p1, g1;
  logic [NG-1:0]    grp_p, grp_g;
  logic [NG:0]      grp_c;

  assign p1 = a1 ^ b1;
  assign g1 = a1 & b1;

  always_comb begin
    grp_p = '0;
    grp_g = '0;
    grp_c = '0;
    for (int k = 0; k < NG; k++) begin
      grp_p[k] = &p1[k*GROUP +: GROUP];
      grp_g[k] = sop_carry(WIDTH'(p1[k*GROUP +: GROUP]),
                           WIDTH'(g1[k*GROUP +: GROUP]), 1'b0, GROUP);
    end
    for (int k = 0; k <= NG; k++) begin
      grp_c[k] = sop_carry(WIDTH'(grp_p), WIDTH'(grp_g), c1, k);
    end
  end

  // ---------------------------------------------------------------------------
  // S2: lookahead register
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] p2, g2;
  logic [NG:0]      gc2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2  <= 1'b0;
      p2  <= '0;
      g2  <= '0;
      gc2 <= '0;
    end else if (acc2) begin
      v2 <= v1;
      if (v1) begin
        p2  <= p1;
        g2  <= g1;
        gc2 <= grp_c;
      end
    end
  end

  // In-group carries seeded by the registered group carry, then sum and flags.
  logic [WIDTH-1:0] bit_c, sum_raw, sum_n;
  logic             cout_n, ovf_n, zero_n;

  always_comb begin
    bit_c = '0;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        bit_c[k*GROUP + j] = sop_carry(WIDTH'(p2[k*GROUP +: GROUP]),
                                       WIDTH'(g2[k*GROUP +: GROUP]), gc2[k], j);
      end
    end
    sum_raw = p2 ^ bit_c;
    cout_n  = gc2[NG];
    ovf_n   = bit_c[WIDTH-1] ^ cout_n;
    sum_n   = sum_raw;
    // Positive overflow never carries out of the MSB; negative overflow does.
    if (SATURATE && ovf_n) begin
      sum_n = cout_n ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    zero_n = (sum_n == '0);
  end

  // ---------------------------------------------------------------------------
  // S3: output register (held while out_valid && !out_ready)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v3     <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (acc3) begin
      v3 <= v2;
      if (v2) begin
        sum_q  <= sum_n;
        cout_q <= cout_n;
        ovf_q  <= ovf_n;
        zero_q <= zero_n;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = v3;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_adder_pipe
//   Scoreboard bench for cla_adder_pipe. Two instances (SATURATE=0 and 1) see
//   identical stimulus; expected results are pushed on acceptance and compared
//   when the output handshake fires. Inputs change on the falling edge and
//   everything is sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_cla_adder_pipe;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic [W-1:0] sat_sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         sat_zero;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         cin;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  cla_adder_pipe_if #(.WIDTH(W)) ifc ();
  cla_adder_pipe_if #(.WIDTH(W)) ifc_s ();

  cla_adder_pipe #(.WIDTH(W), .GROUP(4), .SATURATE(1'b0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  cla_adder_pipe #(.WIDTH(W), .GROUP(4), .SATURATE(1'b1)) dut_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc_s.slave)
  );

  assign ifc_s.in_valid  = ifc.in_valid;
  assign ifc_s.a         = ifc.a;
  assign ifc_s.b         = ifc.b;
  assign ifc_s.op        = ifc.op;
  assign ifc_s.cin       = ifc.cin;
  assign ifc_s.out_ready = ifc.out_ready;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: plain integer arithmetic, independent of lookahead.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input logic cin);
    exp_t         e;
    logic [W-1:0] be;
    logic         c;
    logic [W:0]   full;
    be      = op[0] ? ~b : b;
    c       = (op == 2'b00) ? 1'b0 : (op == 2'b01) ? 1'b1 : (op == 2'b10) ? cin : ~cin;
    full    = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c};
    e.sum   = full[W-1:0];
    e.cout  = full[W];
    e.ovf   = (a[W-1] == be[W-1]) && (e.sum[W-1] != a[W-1]);
    e.zero  = (e.sum == '0);
    e.sat_sum = e.sum;
    if (e.ovf) e.sat_sum = a[W-1] ? 16'h8000 : 16'h7FFF;
    e.sat_zero = (e.sat_sum == '0);
    return e;
  endfunction

  // One cycle: drive on the falling edge, settle, score the output, record
  // whether the input was accepted and push its expected result.
  task automatic tick(input logic v, input vec_t x, input logic ordy,
                      output logic acc, output logic got);
    exp_t e;
    @(negedge clk);
    ifc.in_valid  = v;
    ifc.a         = x.a;
    ifc.b         = x.b;
    ifc.op        = x.op;
    ifc.cin       = x.cin;
    ifc.out_ready = ordy;
    #1;
    got = ifc.out_valid;
    acc = v && ifc.in_ready;
    if (got) begin
      if (exp_q.size() == 0) begin
        check("out_valid_unexpected", ifc.out_valid, 1'b0);
      end else begin
        e = exp_q[0];
        check("sum",       ifc.sum,         e.sum);
        check("cout",      ifc.cout,        e.cout);
        check("ovf",       ifc.ovf,         e.ovf);
        check("zero",      ifc.zero,        e.zero);
        check("sat_valid", ifc_s.out_valid, 1'b1);
        check("sat_sum",   ifc_s.sum,       e.sat_sum);
        check("sat_ovf",   ifc_s.ovf,       e.ovf);
        check("sat_zero",  ifc_s.zero,      e.sat_zero);
        if (ordy) void'(exp_q.pop_front());
      end
    end
    if (acc) exp_q.push_back(model(x.a, x.b, x.op, x.cin));
  endtask

  task automatic drain(input int limit);
    logic acc, got;
    int   n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick(1'b0, '0, 1'b1, acc, got);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  vec_t dir_v[9] = '{
    '{16'hFFFF, 16'h0001, 2'b00, 1'b0},   // wrap to zero, carry out
    '{16'h7FFF, 16'h0001, 2'b00, 1'b0},   // positive signed overflow
    '{16'h0003, 16'h0005, 2'b01, 1'b0},   // subtract with borrow
    '{16'h0005, 16'h0003, 2'b11, 1'b1},   // subtract with borrow-in
    '{16'h0FFF, 16'h0001, 2'b10, 1'b1},   // carry across three groups
    '{16'h8000, 16'h8000, 2'b00, 1'b0},   // negative overflow, add
    '{16'h8000, 16'h0001, 2'b01, 1'b0},   // negative overflow, sub
    '{16'h1234, 16'h1234, 2'b11, 1'b0},   // equal operands -> zero
    '{16'hFFFF, 16'hFFFF, 2'b10, 1'b0}
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic         acc, got;
    int           idx, n;
    vec_t         x;
    vec_t         bp_v[8];
    logic [W-1:0] corner[4];

    corner[0] = 16'h0000; corner[1] = 16'hFFFF;
    corner[2] = 16'h7FFF; corner[3] = 16'h8000;

    // ---- Reset state --------------------------------------------------------
    reset_n       = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.op        = 2'b00;
    ifc.cin       = 1'b0;
    ifc.out_ready = 1'b1;
    #1;
    check("rst_out_valid", ifc.out_valid, 1'b0);
    check("rst_sum",       ifc.sum,       16'h0000);
    check("rst_in_ready",  ifc.in_ready,  1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // ---- Latency on an empty pipe ------------------------------------------
    x = '{16'h1234, 16'h1111, 2'b00, 1'b0};
    tick(1'b1, x, 1'b1, acc, got);
    check("lat_accept", acc, 1'b1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      tick(1'b0, '0, 1'b1, acc, got);
      n++;
    end
    check("latency", n, 3);

    // ---- Directed vectors, back to back ------------------------------------
    idx = 0;
    n   = 0;
    while (idx < 9 && n < 50) begin
      tick(1'b1, dir_v[idx], 1'b1, acc, got);
      if (acc) idx++;
      n++;
    end
    check("dir_all_sent", idx, 9);
    check("dir_throughput", n, 9);
    drain(20);

    // ---- Backpressure: out_ready low on cycles 4..7 ------------------------
    for (int i = 0; i < 8; i++) begin
      bp_v[i] = '{W'(i * 16'h1111 + 16'h0F0F), W'(16'h00F1 * (i + 1)), 2'(i % 4), 1'(i % 2)};
    end
    idx = 0;
    for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
      tick(1'b1, bp_v[idx], !(cyc >= 4 && cyc <= 7), acc, got);
      if (acc) idx++;
      if (cyc >= 4 && cyc <= 7) check("bp_full_in_ready", ifc.in_ready, 1'b0);
      if (cyc == 8)             check("bp_pass_in_ready", ifc.in_ready, 1'b1);
    end
    check("bp_all_sent", idx, 8);
    drain(20);

    // ---- Random traffic with random backpressure and bubbles ---------------
    for (int i = 0; i < 400; i++) begin
      x.a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      x.b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      x.op  = 2'($urandom_range(0, 3));
      x.cin = 1'($urandom_range(0, 1));
      tick($urandom_range(0, 3) != 0, x, $urandom_range(0, 3) != 0, acc, got);
    end
    drain(20);

    // ---- Reset with two transactions in flight -----------------------------
    tick(1'b1, '{16'h7FFF, 16'h0001, 2'b00, 1'b0}, 1'b0, acc, got);
    tick(1'b1, '{16'hFFFF, 16'h0001, 2'b00, 1'b0}, 1'b0, acc, got);
    tick(1'b0, '0, 1'b0, acc, got);
    tick(1'b0, '0, 1'b0, acc, got);
    check("pre_rst_out_valid", ifc.out_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", ifc.out_valid,   1'b0);
    check("mid_rst_sum",       ifc.sum,         16'h0000);
    check("mid_rst_cout",      ifc.cout,        1'b0);
    check("mid_rst_ovf",       ifc.ovf,         1'b0);
    check("mid_rst_zero",      ifc.zero,        1'b0);
    check("mid_rst_sat_valid", ifc_s.out_valid, 1'b0);
    check("mid_rst_in_ready",  ifc.in_ready,    1'b1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, '0, 1'b1, acc, got);
      check("post_rst_idle", ifc.out_valid, 1'b0);
    end

    // ---- Unit works again after reset ---------------------------------------
    tick(1'b1, '{16'h0FFF, 16'h0001, 2'b10, 1'b1}, 1'b1, acc, got);
    check("post_rst_accept", acc, 1'b1);
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Parametrised, pipelined carry-lookahead add/subtract unit. It is the next generation of the team's registered 4-bit CLA adder.
- Datapath is WIDTH bits, organised as WIDTH/GROUP lookahead groups with a second-level group lookahead.
- Three register stages with valid/ready handshake on both sides; bubbles collapse and backpressure stalls the pipe.
- Supports add, subtract, carry-in/borrow-in ops; produces carry, signed overflow and zero flags, with optional signed saturation.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of GROUP, minimum 4.
- GROUP, 4, bits per first-level lookahead group.
- SATURATE, 0, 1 = clamp signed overflow results to 0x7F..F / 0x80..0.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  unit can accept input this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  00 add, 01 sub, 10 add+cin, 11 sub-with-borrow.
- cin  input  1  carry-in (op 10) or borrow-in (op 11); ignored otherwise.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow (pre-saturation).
- zero  output  1  sum (post-saturation) == 0.

Behaviour:
- Reset: asynchronous on reset_n low; all stage valids, sum, cout, ovf, zero and internal registers = 0. in_ready = 1 while out of reset with empty pipe.
- Reset mid-operation: all in-flight transactions are discarded. Nothing is emitted after release until new inputs are accepted.

Effective operands:
- b_eff = b for op[0]=0, ~b for op[0]=1.
- c0 by op: op 00 -> 0; op 01 -> 1; op 10 -> cin; op 11 -> ~cin.

Stage S1 (input register):
- Captures a, b_eff, c0 on in_valid && in_ready.

Stage S2 (lookahead register):
- Registers bit P = a^b_eff and bit G = a&b_eff.
- Registers the group carry-in vector computed combinationally from S1.
- Group Pg = AND of its bit P; group Gg = standard 4-term lookahead within the group, generalised to GROUP bits.
- Carries across groups use the group lookahead: C[k+1] = Gg[k] | Pg[k]&C[k], flattened; no ripple across groups.

Stage S3 (output register):
- sum_raw[i] = P[i] ^ c[i], where c[i] comes from in-group lookahead seeded by the group carry.
- cout = carry out of MSB.
- ovf = c[WIDTH-1] ^ cout.
- SATURATE=1 and ovf=1: sum = 0x7F..F if cout=0, else 0x80..0. Otherwise sum = sum_raw.
- zero computed on the final sum.

Handshake:
- Latency: 3 cycles from accepting edge to out_valid with no stall; throughput 1/cycle.
- acc3 = !out_valid | out_ready.
- acc2 = !v2 | acc3.
- in_ready = !v1 | acc2 (combinational ready chain).
- Each stage loads when its accept is true. Its valid becomes the upstream valid, so bubbles collapse.
- Stalled stages hold data; the output registers hold sum/flags stable while out_valid && !out_ready.
- Simultaneous input and output on the same cycle is allowed when the pipe is full and out_ready=1.
- Full: 3 transactions held and out_ready=0 -> in_ready=0.
- Order is always preserved; no transaction is dropped or duplicated.
- Wrap-around: unsigned overflow wraps modulo 2^WIDTH unless saturated; cout and ovf are always reported.

Test Plan:
- Reset: reset_n low mid-stream with 2 in flight -> sum=0, flags=0, out_valid=0 immediately. After release there is no output until a new input is sent.
- Add wrap (WIDTH=16): a=0xFFFF, b=0x0001, op=00 -> 3 cycles later sum=0x0000, cout=1, zero=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, op=00 -> sum=0x8000, ovf=1, cout=0. With SATURATE=1 -> sum=0x7FFF, ovf=1.
- Subtract and borrow:
  - a=0x0003, b=0x0005, op=01 -> sum=0xFFFE, cout=0.
  - a=0x0005, b=0x0003, op=11, cin=1 -> sum=0x0001, cout=1.
- Cross-group carry: a=0x0FFF, b=0x0001, op=10, cin=1 -> sum=0x1001, cout=0. This checks lookahead carries through 3 groups.
- Backpressure: stream 8 back-to-back inputs with out_ready=0 for cycles 4-7 -> in_ready falls once 3 are held. All 8 results appear in order with stable data during the stall; no loss.
